wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Sequences the single register-file write port between the in-order pipeline writeback (the output of the memtoReg-selected writeback mux) and out-of-band results from the multi-cycle MUL/DIV unit (MDU).
- Pipeline has priority.
- MDU results that lose arbitration are held in a small FIFO and drained into pipeline bubbles.
- If a held result waits too long, the arbiter forces a pipeline stall.
- Exports a pending-destination mask so the hazard unit can block RAW/WAW on buffered registers.

Parameters:
DATA_W, 32, register/result width
ADDR_W, 5, register index width
FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2)
MAX_WAIT, 4, max cycles a buffered head waits for a bubble before a forced stall (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
pipe_regwrite  input  1  WB-stage instruction writes a register
pipe_rd  input  ADDR_W  WB-stage destination
pipe_data  input  DATA_W  WB-stage write data (writeback mux output)
mdu_valid  input  1  MDU result available this cycle
mdu_rd  input  ADDR_W  MDU destination
mdu_data  input  DATA_W  MDU result
mdu_ready  output  1  arbiter accepts MDU result this cycle (= !full)
rf_we  output  1  register-file write enable (also forwarding valid)
rf_waddr  output  ADDR_W  write address
rf_wdata  output  DATA_W  write data
stall_o  output  1  freeze IF..WB this cycle (WB instruction re-presented next cycle)
pend_mask  output  2**ADDR_W  bit r set while a buffered entry targets rd r

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, age=0, stall_o=0, pend_mask=0, mdu_ready=1. While FIFO is empty, rf_* follow the combinational rules below. Buffered results are discarded.
- Pipeline slot definition: the slot is busy when pipe_regwrite=1 and pipe_rd!=0; otherwise it is free.
- Write-port selection, combinational and same cycle, in priority order:
  1. FORCE: drive FIFO head; stall_o=1; pipeline write suppressed.
  2. Slot busy: drive pipe_rd/pipe_data.
  3. Slot free and FIFO non-empty: drive FIFO head and pop.
  4. Slot free, FIFO empty, mdu_valid=1 and mdu_rd!=0: bypass the MDU result directly; no enqueue.
  5. Otherwise rf_we=0; rf_waddr/rf_wdata=0.
- Enqueue: happens when mdu_valid & mdu_ready & mdu_rd!=0 and the result is not bypassed. The FIFO keeps the order of MDU completion.
- mdu_rd==0 results are accepted and dropped.
- mdu_ready is derived from registered occupancy only. Simultaneous pop and enqueue is legal when not full. When full, mdu_valid is ignored; the MDU must hold the result.
- pend_mask is the OR of one-hot decoded rd over valid entries. It is updated on the clock edge after each enqueue/pop.
- FSM states:
  - IDLE: FIFO empty. Enqueue -> PEND.
  - PEND: entered with age=0. Pop and empty-after -> IDLE. Pop and non-empty-after -> PEND with age=0. No pop: age+1; when age==MAX_WAIT-1 -> FORCE.
  - FORCE: one pop per cycle, stall_o=1. Empty-after -> IDLE, else -> PEND with age=0.
- Age counter: width clog2(MAX_WAIT)+1. It saturates and never wraps.
- WAW between a buffered rd and a younger pipeline write is prevented upstream via pend_mask. The bench asserts that pipe_regwrite & pend_mask[pipe_rd] never holds for pipe_rd!=0.

Decomposition:
- Shared package (rv32i_pkg):
  - wb_src_e enum: NONE, PIPE, FIFO, BYPASS.
  - arb_state_e enum: IDLE, PEND, FORCE.
  - The XLEN and REG_ADDR_W constants.
- Sub-module wb_result_fifo: a synchronous DEPTH x (ADDR_W+DATA_W) FIFO with async reset and full/empty/head outputs. It also provides a per-entry valid/rd vector for the pend_mask decode.
- The arbiter holds the FSM, the age counter and the selection mux.

Test Plan:
- Pipeline only: pipe_regwrite=1, rd=5, data=0xDEADBEEF -> same cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, stall_o=0.
- Bypass: pipe_regwrite=0, mdu_valid=1, rd=7, data=0x12345678 -> same cycle write to rd7; pend_mask stays 0; state stays IDLE.
- Conflict: pipe rd=3 and MDU rd=9 in cycle 0 -> cycle 0 writes rd3, pend_mask[9]=1 from cycle 1. First bubble writes rd9 and clears bit 9 on the next edge.
- Starvation (MAX_WAIT=4): pipeline busy every cycle, MDU rd=12 enqueued in cycle 0 -> PEND cycles 1-4, stall_o=1 and rf_waddr=12 in cycle 5. Returns to IDLE in cycle 6 with stall_o=0.
- Full/backpressure: two results buffered while the pipeline is busy -> mdu_ready=0. A third mdu_valid is not accepted; it is accepted the cycle after the first pop.
- Async reset while in FORCE with 2 entries -> stall_o=0, pend_mask=0, mdu_ready=1 immediately; after release the next write comes only from new inputs.
- x0: MDU rd=0 with mdu_valid=1 -> accepted, no write, no enqueue. Pipeline rd=0 with regwrite=1 -> treated as a bubble.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// rv32i_pkg: shared widths and writeback arbitration enums
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {NONE, PIPE, FIFO, BYPASS} wb_src_e;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} arb_state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline/MDU inputs and register-file write port bundle
interface wb_port_arbiter_if import rv32i_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
);
  logic                 pipe_regwrite;
  logic [ADDR_W-1:0]    pipe_rd;
  logic [DATA_W-1:0]    pipe_data;
  logic                 mdu_valid;
  logic [ADDR_W-1:0]    mdu_rd;
  logic [DATA_W-1:0]    mdu_data;
  logic                 mdu_ready;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_wdata;
  logic                 stall_o;
  logic [2**ADDR_W-1:0] pend_mask;
  modport master (
    output pipe_regwrite, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, stall_o, pend_mask
  );
  modport slave (
    input  pipe_regwrite, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, stall_o, pend_mask
  );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// wb_result_fifo: in-order buffer for MDU results that lost the write port
module wb_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [ADDR_W-1:0]             i_rd,
  input  logic [DATA_W-1:0]             i_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_one,
  output logic [ADDR_W-1:0]             o_head_rd,
  output logic [DATA_W-1:0]             o_head_data,
  output logic [DEPTH-1:0]              o_vld,
  output logic [DEPTH-1:0][ADDR_W-1:0]  o_rd
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]                r_wp, r_rp;
  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] r_rd;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_vld <= '0;
    end else begin
      r_wp  <= i_push ? r_wp + 1'b1 : r_wp;
      r_rp  <= i_pop ? r_rp + 1'b1 : r_rp;
      r_vld <= (r_vld & ~(DEPTH'(i_pop) << r_rp)) | (DEPTH'(i_push) << r_wp);
    end
  end
  // payload needs no reset: entries only count through r_vld
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_wp]   <= i_rd;
      r_data[r_wp] <= i_data;
    end
  end
  assign o_full      = &r_vld;
  assign o_empty     = ~|r_vld;
  assign o_one       = $onehot(r_vld);
  assign o_head_rd   = r_rd[r_rp];
  assign o_head_data = r_data[r_rp];
  assign o_vld       = r_vld;
  assign o_rd        = r_rd;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline WB and MDU results
module wb_port_arbiter import rv32i_pkg::*; #(
  parameter int DATA_W     = XLEN,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int AGE_W = $clog2(MAX_WAIT) + 1;
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_PEND  = PEND;
  localparam logic [1:0] S_FORCE = FORCE;
  logic [1:0]                        r_state, w_state_nxt;
  logic [AGE_W-1:0]                  r_age, w_age_nxt;
  logic                              w_busy, w_full, w_empty, w_one, w_pop, w_push, w_empty_after;
  logic [ADDR_W-1:0]                 w_head_rd;
  logic [DATA_W-1:0]                 w_head_data;
  logic [FIFO_DEPTH-1:0]             w_vld;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] w_rd;
  logic [2**ADDR_W-1:0]              w_mask;
  wb_src_e                           w_src;
  wb_result_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop),
    .i_rd(bus.mdu_rd), .i_data(bus.mdu_data),
    .o_full(w_full), .o_empty(w_empty), .o_one(w_one),
    .o_head_rd(w_head_rd), .o_head_data(w_head_data), .o_vld(w_vld), .o_rd(w_rd)
  );
  assign w_busy = bus.pipe_regwrite && bus.pipe_rd != '0;
  assign w_src  = r_state == S_FORCE ? FIFO :
                  w_busy ? PIPE :
                  !w_empty ? FIFO :
                  (bus.mdu_valid && bus.mdu_rd != '0) ? BYPASS : NONE;
  assign w_pop  = w_src == FIFO;
  assign w_push = bus.mdu_valid && !w_full && bus.mdu_rd != '0 && w_src != BYPASS;
  assign w_empty_after = !w_push && (w_empty || (w_pop && w_one));
  assign bus.mdu_ready = !w_full;
  assign bus.stall_o   = r_state == S_FORCE;
  assign bus.rf_we     = w_src != NONE;
  assign bus.rf_waddr  = w_src == PIPE ? bus.pipe_rd : w_src == FIFO ? w_head_rd :
                         w_src == BYPASS ? bus.mdu_rd : '0;
  assign bus.rf_wdata  = w_src == PIPE ? bus.pipe_data : w_src == FIFO ? w_head_data :
                         w_src == BYPASS ? bus.mdu_data : '0;
  assign bus.pend_mask = w_mask;
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (w_vld[i]) w_mask[w_rd[i]] = 1'b1;
  end
  // the head only ages while it sits in PEND without reaching the port
  always_comb begin
    w_state_nxt = w_empty_after ? S_IDLE :
                  (r_state == S_PEND && !w_pop && r_age == AGE_W'(MAX_WAIT - 1)) ? S_FORCE : S_PEND;
    w_age_nxt   = (r_state == S_PEND && !w_pop) ? (&r_age ? r_age : r_age + 1'b1) : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed cycle-by-cycle checks of write-port arbitration
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.pipe_regwrite = pw;
    bus.pipe_rd       = prd;
    bus.pipe_data     = pd;
    bus.mdu_valid     = mv;
    bus.mdu_rd        = mrd;
    bus.mdu_data      = md;
    #2;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input string tag, input logic we, input logic [4:0] a,
                    input logic [31:0] d, input logic st);
    check({tag, "_we"}, 64'(bus.rf_we), 64'(we));
    check({tag, "_addr"}, 64'(bus.rf_waddr), 64'(a));
    check({tag, "_data"}, 64'(bus.rf_wdata), 64'(d));
    check({tag, "_stall"}, 64'(bus.stall_o), 64'(st));
  endtask
  always @(negedge clk)
    if (!rst && bus.pipe_regwrite && bus.pipe_rd != 5'd0)
      check("waw_guard", 64'(bus.pend_mask[bus.pipe_rd]), 64'd0);
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    check("rst_ready", 64'(bus.mdu_ready), 64'd1);
    check("rst_mask", 64'(bus.pend_mask), 64'd0);
    wr("rst", 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
    // pipeline only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    wr("pipe", 1, 5, 32'hDEADBEEF, 0);
    step();
    // bypass
    drive(0, 0, 0, 1, 7, 32'h12345678);
    wr("byp", 1, 7, 32'h12345678, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("byp_mask", 64'(bus.pend_mask), 64'd0);
    wr("byp_after", 0, 0, 0, 0);
    step();
    // conflict
    drive(1, 3, 32'hA3, 1, 9, 32'hA9);
    wr("cf0", 1, 3, 32'hA3, 0);
    check("cf0_mask", 64'(bus.pend_mask), 64'd0);
    step();
    drive(1, 4, 32'hA4, 0, 0, 0);
    wr("cf1", 1, 4, 32'hA4, 0);
    check("cf1_mask", 64'(bus.pend_mask), 64'h200);
    step();
    drive(0, 0, 0, 0, 0, 0);
    wr("cf2", 1, 9, 32'hA9, 0);
    check("cf2_mask", 64'(bus.pend_mask), 64'h200);
    step();
    drive(0, 0, 0, 0, 0, 0);
    wr("cf3", 0, 0, 0, 0);
    check("cf3_mask", 64'(bus.pend_mask), 64'd0);
    step();
    // starvation
    drive(1, 1, 32'h10, 1, 12, 32'hC0C0);
    wr("sv0", 1, 1, 32'h10, 0);
    step();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 5'(c), 32'(c), 0, 0, 0);
      wr($sformatf("sv%0d", c), 1, 5'(c), 32'(c), 0);
      check($sformatf("sv%0d_mask", c), 64'(bus.pend_mask), 64'h1000);
      step();
    end
    drive(1, 4, 32'h4, 0, 0, 0);
    wr("sv5", 1, 12, 32'hC0C0, 1);
    step();
    drive(1, 4, 32'h4, 0, 0, 0);
    wr("sv6", 1, 4, 32'h4, 0);
    check("sv6_mask", 64'(bus.pend_mask), 64'd0);
    step();
    // full / backpressure
    drive(1, 1, 32'h1, 1, 20, 32'hD20);
    check("fb0_ready", 64'(bus.mdu_ready), 64'd1);
    step();
    drive(1, 2, 32'h2, 1, 21, 32'hD21);
    check("fb1_ready", 64'(bus.mdu_ready), 64'd1);
    step();
    drive(1, 3, 32'h3, 1, 22, 32'hD22);
    check("fb2_ready", 64'(bus.mdu_ready), 64'd0);
    check("fb2_mask", 64'(bus.pend_mask), 64'h300000);
    step();
    drive(0, 0, 0, 1, 22, 32'hD22);
    check("fb3_ready", 64'(bus.mdu_ready), 64'd0);
    wr("fb3", 1, 20, 32'hD20, 0);
    step();
    drive(1, 3, 32'h3, 1, 22, 32'hD22);
    check("fb4_ready", 64'(bus.mdu_ready), 64'd1);
    check("fb4_mask", 64'(bus.pend_mask), 64'h200000);
    wr("fb4", 1, 3, 32'h3, 0);
    step();
    drive(1, 4, 32'h4, 0, 0, 0);
    check("fb5_mask", 64'(bus.pend_mask), 64'h600000);
    check("fb5_ready", 64'(bus.mdu_ready), 64'd0);
    step();
    drive(1, 5, 32'h5, 0, 0, 0);
    step();
    drive(1, 6, 32'h6, 0, 0, 0);
    check("fb7_stall", 64'(bus.stall_o), 64'd0);
    step();
    // async reset while forcing with two entries buffered
    drive(1, 6, 32'h6, 0, 0, 0);
    wr("fc", 1, 21, 32'hD21, 1);
    rst = 1'b1;
    #1;
    check("ar_stall", 64'(bus.stall_o), 64'd0);
    check("ar_mask", 64'(bus.pend_mask), 64'd0);
    check("ar_ready", 64'(bus.mdu_ready), 64'd1);
    wr("ar", 1, 6, 32'h6, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 0);
    wr("post_rst", 0, 0, 0, 0);
    check("post_rst_mask", 64'(bus.pend_mask), 64'd0);
    step();
    // x0 handling
    drive(0, 0, 0, 1, 0, 32'hBAD);
    check("x0_ready", 64'(bus.mdu_ready), 64'd1);
    wr("x0_mdu", 0, 0, 0, 0);
    step();
    drive(1, 0, 32'hBAD0, 1, 13, 32'hD13);
    check("x0_mask", 64'(bus.pend_mask), 64'd0);
    wr("x0_pipe", 1, 13, 32'hD13, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("x0_end_mask", 64'(bus.pend_mask), 64'd0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
